gen_sin_dds: RTL and testbench
==============================

# gen_sin_dds

Parametrised direct-digital-synthesis sine generator: a phase accumulator with a runtime tuning word drives a quarter-wave amplitude ROM. Quadrant folding, sign and offset are applied in a 3-stage pipeline, with a runtime attenuation shift. It feeds the DAC/display paths with an offset-binary sample stream and an optional quadrature (cosine) channel.

## Interface
- PW, 16: phase accumulator width; must satisfy PW ≥ AW+2.
- AW, 5: quarter-table index bits; the table holds 2^AW+1 entries.
- DW, 12: sample width.
- NA, 2^(DW-1)-1: peak amplitude.
- NS, 2^(DW-1): output offset (mid-scale).
- FTW_INIT, 1<<(PW-AW-2): tuning word loaded at reset.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- ce  in  1  sample enable; one new sample per ce=1 clock.
- ftw  in  PW  tuning word (phase increment).
- ftw_ld  in  1  load ftw into the internal ftw_r register.
- sync  in  1  phase restart.
- att  in  3  attenuation shift; magnitude is >> att.
- valid  out  1  SIN/COS/S/Y hold a new sample.
- S  out  1  sign; 1 means sin ≥ 0.
- Y  out  DW-1  unshifted magnitude.
- SIN  out  DW  S ? NS+(Y>>att) : NS-(Y>>att).
- COS  out  DW  quadrature output; present only with GEN_SIN_DDS_COS_EN.

## Operation
- **Accumulator acc.** On a ce=1 edge: acc <= acc+ftw_r, mod 2^PW.
- **Quadrant and index.** q = acc[PW-1:PW-2]. i = acc[PW-3:PW-2-AW]. Lower bits are fraction and are truncated.
- **Fold.** ROM address a = q[0] ? 2^AW-i : i, width AW+1. Sign S = ~q[1].
- **ROM contents.** ROM[k] = round(NA·sin(π/2·k/2^AW)), k = 0..2^AW. ROM[0]=0, ROM[2^AW]=NA.
- **ftw_ld.** ftw_r <= ftw. The new value is used from the next ce edge onward. If ftw_ld and ce are both 1 on the same edge, the accumulation uses the old ftw_r.
- **sync.** acc <= 0, overriding the accumulation. If ce is also 1, stage 1 still captures the pre-sync acc. The next sample is then phase 0.
- **Output arithmetic.**
  - Ya = Y >> att, a logical shift.
  - SIN is computed unsigned in DW bits. It never overflows: range is NS-NA to NS+NA.
  - At Y=0, SIN = NS regardless of S.
- **COS.** COS uses phase acc+2^(PW-2), i.e. quadrant q+1, through a second read port of the same ROM. It applies the same att and the same pipeline.

## Timing
- **Stage 1 (ce edge).** Captures q and a from the current acc and advances acc.
- **Stage 2.** Registered ROM read gives Y and S.
- **Stage 3.** Registers SIN/COS using the att value sampled on this edge. valid = ce delayed by 3 clocks.
- **Latency.** 3 clocks from the ce edge to valid=1. Throughput is one sample per clock when ce is held at 1.
- **Between samples.** When ce=0, stages still advance. valid falls 3 clocks later. SIN/COS/S/Y hold their last value; valid alone marks new data.
- **Reset values.** acc=0, ftw_r=FTW_INIT, valid=0, S=0, Y=0, SIN=NS, COS=NS. The valid pipeline clears.
- **rst priority.** rst overrides ce, sync and ftw_ld. Asserting rst mid-stream drops all in-flight samples. No valid follows for 3 clocks after the first ce following reset release.

## Configuration
- GEN_SIN_DDS_COS_EN defined:
  - COS port present.
  - Second ROM read port instantiated.
- GEN_SIN_DDS_COS_EN undefined:
  - COS port and the second ROM port are absent.
  - All other behaviour is identical.

## Structure
- **Shared parameters file.** Holds the default NS, NA and DW constants and the GEN_SIN_DDS_COS_EN default.
- **Sub-module rom_qsin.** Quarter-wave ROM with two synchronous read ports (adr0/DO0, adr1/DO1). Parameters AW and NA; contents are generated at elaboration.
- **Top level.** Contains the accumulator, fold, sign and offset logic.

## Test plan
All scenarios use PW=8, AW=5, DW=12, NA=2047, NS=2048.
- **Reset.** rst=1 for 2 clocks → valid=0, SIN=2048, COS=2048. Then ftw=2, ftw_ld=1, ce=1 continuous → first valid 3 clocks after the first ce; sample 0 has SIN=2048.
- **Full period.** ftw=2 → exactly 128 valid samples per period.
  - Phase 64 → SIN=4095, S=1.
  - Phase 192 → SIN=1, S=0.
  - Phase 128 → SIN=2048.
  - Sequence is symmetric about quadrant boundaries.
- **Attenuation.** att=5 at the phase-64 sample → SIN=2048+63=2111. att=5 at phase 192 → SIN=1985.
- **Tuning change and sync.**
  - ftw_ld with ftw=4 coincident with ce → the old increment is applied once, then steps of 4.
  - sync at acc=100 with ce=1 → this sample uses phase 100; the next sample is phase 0 (SIN=2048).
- **Gapped ce and reset mid-stream.** ce toggling 1,0,1,0 → valid pattern 1,0,1,0 delayed 3 clocks. rst asserted with 2 samples in flight → neither produces a valid.
- **COS (GEN_SIN_DDS_COS_EN).** Phase 0 → COS=4095. Phase 64 → COS=2048. Phase 128 → COS=1. COS equals the SIN sample 32 samples later when ftw=2.

Source files
------------

// File: rtl/gen_sin_dds_pkg.sv
// Shared constants and the elaboration-time quarter-sine generator for gen_sin_dds.
// The quadrature channel is built only when GEN_SIN_DDS_COS_EN is defined (default: undefined).
package gen_sin_dds_pkg;

    localparam int DW_DEF = 12;
    localparam int NA_DEF = (1 << (DW_DEF - 1)) - 1;
    localparam int NS_DEF = 1 << (DW_DEF - 1);

`ifdef GEN_SIN_DDS_COS_EN
    localparam bit COS_EN = 1'b1;
`else
    localparam bit COS_EN = 1'b0;
`endif

    // Q30 fixed point keeps every Taylor product inside 64 bits for angles up to pi/2.
    localparam int     QF   = 30;
    localparam longint PI_Q = 64'sd3373259426;

    // round(na * sin(pi/2 * k / 2^aw)) using an integer Taylor series.
    function automatic longint qsin_val(input int k, input int aw, input int na);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (PI_Q * longint'(k)) / (longint'(2) << aw);
        x2   = (x * x) >>> QF;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) >>> QF) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return ((longint'(na) * sum) + (longint'(1) <<< (QF - 1))) >>> QF;
    endfunction

endpackage

// File: rtl/gen_sin_dds_if.sv
// Control/sample bundle for gen_sin_dds; COS exists only with GEN_SIN_DDS_COS_EN.
interface gen_sin_dds_if
    import gen_sin_dds_pkg::*;
#(
    parameter int PW = 16,
    parameter int DW = DW_DEF
);

    logic          ce;
    logic [PW-1:0] ftw;
    logic          ftw_ld;
    logic          sync;
    logic [2:0]    att;

    logic          valid;
    logic          S;
    logic [DW-2:0] Y;
    logic [DW-1:0] SIN;

`ifdef GEN_SIN_DDS_COS_EN
    logic [DW-1:0] COS;

    modport master (output ce, ftw, ftw_ld, sync, att,
                    input  valid, S, Y, SIN, COS);
    modport slave  (input  ce, ftw, ftw_ld, sync, att,
                    output valid, S, Y, SIN, COS);
`else
    modport master (output ce, ftw, ftw_ld, sync, att,
                    input  valid, S, Y, SIN);
    modport slave  (input  ce, ftw, ftw_ld, sync, att,
                    output valid, S, Y, SIN);
`endif

endinterface

// File: rtl/gen_sin_dds_rom_qsin.sv
// Quarter-wave sine ROM (2^AW+1 entries) with synchronous read ports; port 1 only with GEN_SIN_DDS_COS_EN.
module rom_qsin
    import gen_sin_dds_pkg::*;
#(
    parameter int AW  = 5,
    parameter int NA  = NA_DEF,
    parameter int DOW = $clog2(NA + 1)
) (
    input  logic           clk,
    input  logic [AW:0]    adr0,
    output logic [DOW-1:0] DO0
`ifdef GEN_SIN_DDS_COS_EN
    ,
    input  logic [AW:0]    adr1,
    output logic [DOW-1:0] DO1
`endif
);

    logic [DOW-1:0] rom [(1 << AW) + 1];

    for (genvar k = 0; k <= (1 << AW); k++) begin : g_rom
        localparam logic [DOW-1:0] VAL = DOW'(qsin_val(k, AW, NA));
        assign rom[k] = VAL;
    end

    logic [DOW-1:0] do0_d, do0_q;

    always_comb begin
        do0_d = rom[adr0];
    end

    // NOTE: read registers are not reset; nothing downstream consumes them before a valid address has been read.
    always_ff @(posedge clk) begin
        do0_q <= do0_d;
    end

    assign DO0 = do0_q;

`ifdef GEN_SIN_DDS_COS_EN
    logic [DOW-1:0] do1_d, do1_q;

    always_comb begin
        do1_d = rom[adr1];
    end

    always_ff @(posedge clk) begin
        do1_q <= do1_d;
    end

    assign DO1 = do1_q;
`endif

endmodule

// File: rtl/gen_sin_dds.sv
// DDS sine generator: phase accumulator, quadrant fold, quarter-wave ROM and offset-binary output pipeline.
// Defining GEN_SIN_DDS_COS_EN adds the quadrature (COS) channel through a second ROM read port.
module gen_sin_dds
    import gen_sin_dds_pkg::*;
#(
    parameter int PW       = 16,
    parameter int AW       = 5,
    parameter int DW       = DW_DEF,
    parameter int NA       = (1 << (DW - 1)) - 1,
    parameter int NS       = 1 << (DW - 1),
    parameter int FTW_INIT = 1 << (PW - AW - 2)
) (
    input  logic         clk,
    input  logic         rst,
    gen_sin_dds_if.slave bus
);

    localparam int             YW      = DW - 1;
    localparam logic [PW-1:0]  FTW_RST = PW'(FTW_INIT);
    localparam logic [DW-1:0]  NS_V    = DW'(NS);

    typedef logic [AW:0] addr_t;

    function automatic addr_t fold(input logic q0, input logic [AW-1:0] idx);
        return q0 ? addr_t'(1 << AW) - addr_t'(idx) : addr_t'(idx);
    endfunction

    function automatic logic [DW-1:0] offset(input logic sgn, input logic [YW-1:0] mag,
                                             input logic [2:0] sh);
        logic [DW-1:0] ya;
        ya = DW'(mag >> sh);
        return sgn ? NS_V + ya : NS_V - ya;
    endfunction

    logic [PW-1:0] acc_d, acc_q;
    logic [PW-1:0] ftw_d, ftw_q;
    logic [1:0]    quad;
    logic [AW-1:0] idx;

    // Stage 1: folded address and sign.
    addr_t         a1_d, a1_q;
    logic          s1_d, s1_q;
    logic          v1_d, v1_q;
    // Stage 2: ROM read (inside rom_qsin) plus aligned sign.
    logic          s2_d, s2_q;
    logic          v2_d, v2_q;
    logic [YW-1:0] do0;
    // Stage 3: output registers.
    logic          s3_d, s3_q;
    logic [YW-1:0] y3_d, y3_q;
    logic [DW-1:0] sin_d, sin_q;
    logic          v3_d, v3_q;

    assign quad = acc_q[PW-1 -: 2];
    assign idx  = acc_q[PW-3 -: AW];

`ifdef GEN_SIN_DDS_COS_EN
    logic [1:0]    quad_c;
    addr_t         ac1_d, ac1_q;
    logic          sc1_d, sc1_q;
    logic          sc2_d, sc2_q;
    logic [YW-1:0] do1;
    logic [DW-1:0] cos_d, cos_q;

    // A quarter-turn ahead only changes the quadrant; the in-quadrant index is shared.
    assign quad_c = quad + 2'd1;
`endif

    // NOTE: every *_d gets a hold default first so no path through this block infers a latch.
    always_comb begin
        acc_d = acc_q;
        ftw_d = ftw_q;
        a1_d  = a1_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        s3_d  = s3_q;
        y3_d  = y3_q;
        sin_d = sin_q;
        v1_d  = bus.ce;
        v2_d  = v1_q;
        v3_d  = v2_q;

        if (bus.ftw_ld) begin
            ftw_d = bus.ftw;
        end
        if (bus.ce) begin
            acc_d = acc_q + ftw_q;
            a1_d  = fold(quad[0], idx);
            s1_d  = ~quad[1];
        end
        // Restart wins over accumulation, but stage 1 above has already taken the old phase.
        if (bus.sync) begin
            acc_d = '0;
        end
        if (v1_q) begin
            s2_d = s1_q;
        end
        if (v2_q) begin
            s3_d  = s2_q;
            y3_d  = do0;
            sin_d = offset(s2_q, do0, bus.att);
        end
    end

`ifdef GEN_SIN_DDS_COS_EN
    always_comb begin
        ac1_d = ac1_q;
        sc1_d = sc1_q;
        sc2_d = sc2_q;
        cos_d = cos_q;
        if (bus.ce) begin
            ac1_d = fold(quad_c[0], idx);
            sc1_d = ~quad_c[1];
        end
        if (v1_q) begin
            sc2_d = sc1_q;
        end
        if (v2_q) begin
            cos_d = offset(sc2_q, do1, bus.att);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ftw_q <= FTW_RST;
            a1_q  <= '0;
            s1_q  <= 1'b0;
            v1_q  <= 1'b0;
            s2_q  <= 1'b0;
            v2_q  <= 1'b0;
            s3_q  <= 1'b0;
            y3_q  <= '0;
            sin_q <= NS_V;
            v3_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ftw_q <= ftw_d;
            a1_q  <= a1_d;
            s1_q  <= s1_d;
            v1_q  <= v1_d;
            s2_q  <= s2_d;
            v2_q  <= v2_d;
            s3_q  <= s3_d;
            y3_q  <= y3_d;
            sin_q <= sin_d;
            v3_q  <= v3_d;
        end
    end

`ifdef GEN_SIN_DDS_COS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ac1_q <= '0;
            sc1_q <= 1'b0;
            sc2_q <= 1'b0;
            cos_q <= NS_V;
        end else begin
            ac1_q <= ac1_d;
            sc1_q <= sc1_d;
            sc2_q <= sc2_d;
            cos_q <= cos_d;
        end
    end
`endif

    rom_qsin #(
        .AW  (AW),
        .NA  (NA),
        .DOW (YW)
    ) u_rom (
        .clk  (clk),
        .adr0 (a1_q),
        .DO0  (do0)
`ifdef GEN_SIN_DDS_COS_EN
        ,
        .adr1 (ac1_q),
        .DO1  (do1)
`endif
    );

    assign bus.valid = v3_q;
    assign bus.S     = s3_q;
    assign bus.Y     = y3_q;
    assign bus.SIN   = sin_q;
`ifdef GEN_SIN_DDS_COS_EN
    assign bus.COS   = cos_q;
`endif

endmodule

// File: tb/tb_gen_sin_dds.sv
// Directed bench for gen_sin_dds (PW=8, AW=5, DW=12) with a real-valued sine scoreboard.
module tb_gen_sin_dds;

    localparam real PI = 3.14159265358979323846;

    typedef struct {
        logic [7:0]  ph;
        logic [2:0]  att;
        logic        s;
        logic [10:0] y;
        logic [11:0] sin;
        logic [11:0] cos;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   vcnt   = 0;
    smp_t sb[$];
    logic [7:0] m_acc = 8'd0;
    logic [7:0] m_ftw = 8'd2;

    gen_sin_dds_if #(.PW(8), .DW(12)) bus ();

    gen_sin_dds #(
        .PW(8), .AW(5), .DW(12), .NA(2047), .NS(2048), .FTW_INIT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mag(input logic [7:0] pt);
        real r;
        r = $sin(2.0 * PI * real'(pt) / 256.0);
        if (r < 0.0) r = -r;
        return $rtoi(2047.0 * r + 0.5);
    endfunction

    function automatic smp_t model(input logic [7:0] ph, input logic [2:0] a);
        smp_t m;
        logic [7:0] pt;
        logic [7:0] pc;
        int y;
        int yc;
        pt = ph & 8'hFE;
        pc = pt + 8'd64;
        y  = mag(pt);
        yc = mag(pc);
        m.ph  = ph;
        m.att = a;
        m.s   = (pt < 8'd128);
        m.y   = 11'(y);
        m.sin = m.s ? 12'(2048 + (y >> a)) : 12'(2048 - (y >> a));
        m.cos = (pc < 8'd128) ? 12'(2048 + (yc >> a)) : 12'(2048 - (yc >> a));
        return m;
    endfunction

    task automatic cyc(input logic c, input logic ld = 1'b0, input logic [7:0] f = 8'd0,
                       input logic sy = 1'b0);
        bus.ce     = c;
        bus.ftw_ld = ld;
        bus.ftw    = f;
        bus.sync   = sy;
        if (c) begin
            sb.push_back(model(m_acc, bus.att));
            m_acc = m_acc + m_ftw;
        end
        if (sy) m_acc = 8'd0;
        if (ld) m_ftw = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    always @(negedge clk) begin
        smp_t m;
        if (!rst && bus.valid === 1'b1) begin
            vcnt++;
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                m = sb.pop_front();
                check("sin", 32'(bus.SIN), 32'(m.sin));
                check("s", 32'(bus.S), 32'(m.s));
                check("y", 32'(bus.Y), 32'(m.y));
`ifdef GEN_SIN_DDS_COS_EN
                check("cos", 32'(bus.COS), 32'(m.cos));
                if (m.att == 3'd0 && m.ph == 8'd0)   check("cos_ph0", 32'(bus.COS), 32'd4095);
                if (m.att == 3'd0 && m.ph == 8'd64)  check("cos_ph64", 32'(bus.COS), 32'd2048);
                if (m.att == 3'd0 && m.ph == 8'd128) check("cos_ph128", 32'(bus.COS), 32'd1);
`endif
                if (m.att == 3'd0 && m.ph == 8'd0)   check("sin_ph0", 32'(bus.SIN), 32'd2048);
                if (m.att == 3'd0 && m.ph == 8'd64)  check("sin_ph64", 32'(bus.SIN), 32'd4095);
                if (m.att == 3'd0 && m.ph == 8'd64)  check("s_ph64", 32'(bus.S), 32'd1);
                if (m.att == 3'd0 && m.ph == 8'd128) check("sin_ph128", 32'(bus.SIN), 32'd2048);
                if (m.att == 3'd0 && m.ph == 8'd192) check("sin_ph192", 32'(bus.SIN), 32'd1);
                if (m.att == 3'd0 && m.ph == 8'd192) check("s_ph192", 32'(bus.S), 32'd0);
                if (m.att == 3'd5 && m.ph == 8'd64)  check("att5_ph64", 32'(bus.SIN), 32'd2111);
                if (m.att == 3'd5 && m.ph == 8'd192) check("att5_ph192", 32'(bus.SIN), 32'd1985);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ce_pat [6];
        logic v_pat  [6];
        ce_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        v_pat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        bus.ce = 1'b0; bus.ftw = 8'd0; bus.ftw_ld = 1'b0; bus.sync = 1'b0; bus.att = 3'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_sin", 32'(bus.SIN), 32'd2048);
        check("rst_s", 32'(bus.S), 32'd0);
        check("rst_y", 32'(bus.Y), 32'd0);
`ifdef GEN_SIN_DDS_COS_EN
        check("rst_cos", 32'(bus.COS), 32'd2048);
`endif
        rst = 1'b0;

        // First-sample latency, then one full period at ftw=2.
        vcnt = 0;
        cyc(1'b1, 1'b1, 8'd2);
        check("lat_v0", 32'(bus.valid), 32'd0);
        cyc(1'b1);
        check("lat_v1", 32'(bus.valid), 32'd0);
        cyc(1'b1);
        check("lat_v2", 32'(bus.valid), 32'd1);
        check("first_sin", 32'(bus.SIN), 32'd2048);
        for (int i = 0; i < 125; i++) cyc(1'b1);
        idle(4);
        check("period_count", 32'(vcnt), 32'd128);

        // Attenuated period.
        bus.att = 3'd5;
        for (int i = 0; i < 128; i++) cyc(1'b1);
        idle(4);
        bus.att = 3'd0;

        // Tuning change coincident with ce, then sync at phase 100.
        cyc(1'b1, 1'b1, 8'd4);
        for (int i = 0; i < 8; i++) cyc(1'b1);
        cyc(1'b0, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b1);
        cyc(1'b1, 1'b0, 8'd0, 1'b1);
        cyc(1'b1);
        idle(4);

        // Gapped ce.
        for (int i = 0; i < 6; i++) begin
            cyc(ce_pat[i]);
            check($sformatf("gap_v%0d", i), 32'(bus.valid), 32'(v_pat[i]));
        end
        idle(2);

        // Reset with two samples in flight.
        cyc(1'b1);
        cyc(1'b1);
        rst = 1'b1;
        bus.ce = 1'b0;
        sb.delete();
        m_acc = 8'd0;
        m_ftw = 8'd2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_flush_v%0d", i), 32'(bus.valid), 32'd0);
            cyc(1'b0);
        end
        cyc(1'b1);
        check("post_rst_v0", 32'(bus.valid), 32'd0);
        cyc(1'b1);
        check("post_rst_v1", 32'(bus.valid), 32'd0);
        cyc(1'b1);
        check("post_rst_v2", 32'(bus.valid), 32'd1);
        idle(4);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
